// File: rtl/div_seq_frontend.sv
// Front-end sequencer for the shift/subtract divider core: it takes operand magnitudes in, runs the core and
// sign-corrects the result. Divide-by-zero and signed overflow are answered locally, and a watchdog bounds the core run.
module div_seq_frontend #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 80
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_signed,
  input  logic [WIDTH-1:0]   in_dividend,
  input  logic [WIDTH-1:0]   in_divisor,
  output logic               core_rst,
  output logic               core_run,
  output logic [WIDTH-1:0]   core_dividend,
  output logic [WIDTH-1:0]   core_divisor,
  input  logic               core_ready,
  input  logic [2*WIDTH-1:0] core_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_quotient,
  output logic [WIDTH-1:0]   out_remainder,
  output logic               out_dbz,
  output logic               out_err
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, LOAD, RUN, FIX, DONE} state_t;

  state_t             state;
  logic [CW-1:0]      wd_cnt;
  logic               neg_q, neg_r, dbz, ovf, err;
  logic [WIDTH-1:0]   dividend_orig;
  logic [2*WIDTH-1:0] result;

  logic             a_neg, b_neg, is_dbz, is_ovf;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  always_comb begin
    a_neg  = in_signed & in_dividend[WIDTH-1];
    b_neg  = in_signed & in_divisor[WIDTH-1];
    a_mag  = a_neg ? (~in_dividend + 1'b1) : in_dividend;
    b_mag  = b_neg ? (~in_divisor + 1'b1) : in_divisor;
    is_dbz = (in_divisor == '0);
    is_ovf = in_signed & (in_dividend == MIN_NEG) & (&in_divisor);
    // The core returns {remainder, quotient} of the magnitudes; the signs are restored here.
    q_fix  = neg_q ? (~result[WIDTH-1:0] + 1'b1) : result[WIDTH-1:0];
    r_fix  = neg_r ? (~result[2*WIDTH-1:WIDTH] + 1'b1) : result[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      core_rst      <= 1'b0;
      core_run      <= 1'b0;
      core_dividend <= '0;
      core_divisor  <= '0;
      out_valid     <= 1'b0;
      out_quotient  <= '0;
      out_remainder <= '0;
      out_dbz       <= 1'b0;
      out_err       <= 1'b0;
      wd_cnt        <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      dbz           <= 1'b0;
      ovf           <= 1'b0;
      err           <= 1'b0;
      dividend_orig <= '0;
      result        <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          in_ready      <= 1'b0;
          dividend_orig <= in_dividend;
          neg_q         <= a_neg ^ b_neg;
          neg_r         <= a_neg;
          dbz           <= is_dbz;
          ovf           <= is_ovf & ~is_dbz;
          err           <= 1'b0;
          wd_cnt        <= '0;
          core_dividend <= a_mag;
          core_divisor  <= b_mag;
          if (is_dbz || is_ovf) begin
            state <= FIX;
          end else begin
            state    <= LOAD;
            core_rst <= 1'b1;
          end
        end
        LOAD: begin
          core_rst <= 1'b0;
          core_run <= 1'b1;
          state    <= RUN;
        end
        RUN: begin
          wd_cnt <= wd_cnt + 1'b1;
          // A ready seen on the last allowed cycle still counts as a completion.
          if (core_ready) begin
            result   <= core_result;
            core_run <= 1'b0;
            state    <= FIX;
          end else if (wd_cnt + 1'b1 == CW'(TIMEOUT)) begin
            err      <= 1'b1;
            core_run <= 1'b0;
            state    <= FIX;
          end
        end
        FIX: begin
          if (dbz) begin
            out_quotient  <= '1;
            out_remainder <= dividend_orig;
            out_dbz       <= 1'b1;
          end else if (ovf) begin
            out_quotient  <= MIN_NEG;
            out_remainder <= '0;
          end else if (err) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_err       <= 1'b1;
          end else begin
            out_quotient  <= q_fix;
            out_remainder <= r_fix;
          end
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          out_dbz   <= 1'b0;
          out_err   <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
